ctx_fetch: RTL and testbench

//  Context read sequencer: the consumer side of the dual-port context RAM.
//  On start, walks ctx_len words from base_addr for `loops` passes, issuing reads on one RAM port
//  (1-cycle registered read latency) and presenting each word on a valid/ready stream to the PE-array config loader.
//  A 2-entry skid FIFO absorbs the read latency under backpressure; full throughput is 1 word/cycle.

---
 rtl/ctx_fetch_pkg.sv | 13 +
 rtl/ctx_skid_fifo.sv | 65 ++++++
 rtl/ctx_fetch.sv | 138 +++++++++++++
 tb/tb_ctx_fetch.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctx_fetch_pkg.sv
// rtl/ctx_fetch_pkg.sv - shared state encoding and default widths for the context read sequencer
package ctx_fetch_pkg;
    localparam int AWIDTH_DEF = 10;
    localparam int DWIDTH_DEF = 32;
    localparam int LWIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/ctx_skid_fifo.sv
// rtl/ctx_skid_fifo.sv - 2-entry skid FIFO absorbing the context RAM read latency
module ctx_skid_fifo #(
    parameter int W = 34
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic [1:0]   occ
);
    logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
    logic [1:0]   occ_q, occ_d;

    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        occ_d = occ_q;
        if (flush) begin
            occ_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ_q == 2'd0) e0_d = push_data;
                    else               e1_d = push_data;
                    occ_d = occ_q + 2'd1;
                end
                2'b01: begin
                    if (occ_q != 2'd0) begin
                        e0_d  = e1_q;
                        occ_d = occ_q - 2'd1;
                    end
                end
                2'b11: begin
                    // Entry 0 is always the head, so a pop at occ 2 shifts before the new word lands
                    if (occ_q == 2'd2) begin
                        e0_d = e1_q;
                        e1_d = push_data;
                    end else begin
                        e0_d  = push_data;
                        occ_d = 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_q  <= '0;
            e1_q  <= '0;
            occ_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            occ_q <= occ_d;
        end
    end

    assign head_data = e0_q;
    assign occ       = occ_q;
endmodule

// File: rtl/ctx_fetch.sv
// rtl/ctx_fetch.sv - walks ctx_len words from base_addr for `loops` passes and streams them out
module ctx_fetch
    import ctx_fetch_pkg::*;
#(
    parameter int AWIDTH = AWIDTH_DEF,
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int LWIDTH = LWIDTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [AWIDTH-1:0] base_addr,
    input  logic [AWIDTH:0]   ctx_len,
    input  logic [LWIDTH-1:0] loops,
    output logic              busy,
    output logic              done,
    output logic              ram_en,
    output logic [AWIDTH-1:0] ram_addr,
    input  logic [DWIDTH-1:0] ram_rdata,
    output logic              cfg_valid,
    input  logic              cfg_ready,
    output logic [DWIDTH-1:0] cfg_data,
    output logic              cfg_last,
    output logic              cfg_final
);
    localparam int FW = DWIDTH + 2;

    state_t              state_q, state_d;
    logic [AWIDTH-1:0]   addr_q, addr_d, base_q, base_d;
    logic [AWIDTH:0]     len_q, len_d, word_q, word_d;
    logic [LWIDTH-1:0]   loops_q, loops_d, pass_q, pass_d;
    logic                out_q, out_d;
    logic [1:0]          tag_q, tag_d;
    logic [FW-1:0]       head;
    logic [1:0]          occ;
    logic                pop, credit, is_last, is_final;

    ctx_skid_fifo #(.W(FW)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (abort),
        .push      (out_q),
        .push_data ({tag_q, ram_rdata}),
        .pop       (pop),
        .head_data (head),
        .occ       (occ)
    );

    assign cfg_valid = (occ != 2'd0);
    assign pop       = cfg_valid & cfg_ready;
    assign cfg_data  = head[DWIDTH-1:0];
    assign cfg_final = head[DWIDTH];
    assign cfg_last  = head[DWIDTH+1];
    assign ram_addr  = addr_q;
    assign busy      = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
    assign done      = (state_q == ST_DONE);

    // Buffered words plus the read in flight may never exceed the two FIFO slots
    assign credit   = ({1'b0, occ} + {2'b00, out_q}) < (3'd2 + {2'b00, pop});
    assign is_last  = (word_q == len_q - (AWIDTH+1)'(1));
    assign is_final = is_last && (pass_q == loops_q - LWIDTH'(1));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        base_d  = base_q;
        len_d   = len_q;
        loops_d = loops_q;
        word_d  = word_q;
        pass_d  = pass_q;
        tag_d   = tag_q;
        ram_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    len_d   = ctx_len;
                    loops_d = loops;
                    addr_d  = base_addr;
                    word_d  = '0;
                    pass_d  = '0;
                    state_d = (ctx_len == '0 || loops == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (credit) begin
                    ram_en = 1'b1;
                    tag_d  = {is_last, is_final};
                    if (is_last) begin
                        word_d = '0;
                        addr_d = base_q;
                        pass_d = pass_q + LWIDTH'(1);
                        if (is_final) state_d = ST_DRAIN;
                    end else begin
                        word_d = word_q + (AWIDTH+1)'(1);
                        addr_d = addr_q + AWIDTH'(1);
                    end
                end
            end
            ST_DRAIN: begin
                // Finishing on the final pop lets done follow the last handshake directly
                if (!out_q && (occ == 2'd0 || (occ == 2'd1 && pop))) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        out_d = ram_en;
        if (abort) begin
            state_d = ST_IDLE;
            out_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            base_q  <= '0;
            len_q   <= '0;
            loops_q <= '0;
            word_q  <= '0;
            pass_q  <= '0;
            out_q   <= 1'b0;
            tag_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            base_q  <= base_d;
            len_q   <= len_d;
            loops_q <= loops_d;
            word_q  <= word_d;
            pass_q  <= pass_d;
            out_q   <= out_d;
            tag_q   <= tag_d;
        end
    end
endmodule

// File: tb/tb_ctx_fetch.sv
// tb/tb_ctx_fetch.sv - directed bench for ctx_fetch with a word-list scoreboard and RAM model
module tb_ctx_fetch;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   ctx_len = '0;
    logic [LW-1:0] loops = '0;
    logic          busy, done, ram_en, cfg_valid, cfg_last, cfg_final;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_rdata = '0;
    logic [DW-1:0] cfg_data;
    logic          cfg_ready = 1'b1;

    ctx_fetch #(.AWIDTH(AW), .DWIDTH(DW), .LWIDTH(LW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .base_addr (base_addr),
        .ctx_len   (ctx_len),
        .loops     (loops),
        .busy      (busy),
        .done      (done),
        .ram_en    (ram_en),
        .ram_addr  (ram_addr),
        .ram_rdata (ram_rdata),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_data  (cfg_data),
        .cfg_last  (cfg_last),
        .cfg_final (cfg_final)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {6'h2B, a, 6'h15, a};
    endfunction

    always @(posedge clk) if (ram_en) ram_rdata <= mem_word(ram_addr);

    int nvec = 0, nerr = 0;
    logic [DW+1:0] exp_w[0:63];
    logic [AW-1:0] exp_a[0:63];
    logic [AW-1:0] addr_log[0:63];
    int exp_n = 0, gen = 0, start_cyc = 0;
    int idx, aidx, first_valid_cyc, done_cyc, final_cyc;
    int done_cnt, en_cnt, valid_cnt, last_cnt, final_cnt;
    bit rnd_ready = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected word list: every pass walks len addresses from base, wrapping at 2**AW
    task automatic build(input logic [AW-1:0] b, input int len, input int lp);
        int n = 0;
        for (int p = 0; p < lp; p++)
            for (int i = 0; i < len; i++) begin
                logic [AW-1:0] a;
                a = b + AW'(i);
                exp_a[n] = a;
                exp_w[n] = {(i == len - 1), (i == len - 1 && p == lp - 1), mem_word(a)};
                n++;
            end
        exp_n = n;
        gen++;
    endtask

    task automatic compare_loop();
        int seen_gen = -1;
        int inflight = 0;
        bit hold = 0;
        logic [DW+1:0] held = '0;
        forever begin
            @(negedge clk);
            if (gen != seen_gen) begin
                seen_gen = gen;
                idx = 0; aidx = 0; inflight = 0; hold = 0;
                first_valid_cyc = -1; done_cyc = -1; final_cyc = -1;
                done_cnt = 0; en_cnt = 0; valid_cnt = 0; last_cnt = 0; final_cnt = 0;
            end
            if (rst_n) begin
                if (ram_en) begin
                    en_cnt++;
                    if (aidx < 64) addr_log[aidx] = ram_addr;
                    if (aidx < exp_n) chk("ram_addr", 64'(ram_addr), 64'(exp_a[aidx]));
                    else chk("extra_read", 64'(1), 64'(0));
                    aidx++;
                end
                if (cfg_valid) begin
                    valid_cnt++;
                    if (first_valid_cyc < 0) first_valid_cyc = cyc;
                end
                if (hold) chk("hold_stable", 64'({cfg_valid, cfg_last, cfg_final, cfg_data}), 64'({1'b1, held}));
                if (cfg_valid && cfg_ready) begin
                    if (idx < exp_n) chk("word", 64'({cfg_last, cfg_final, cfg_data}), 64'(exp_w[idx]));
                    else chk("extra_word", 64'(1), 64'(0));
                    if (cfg_last) last_cnt++;
                    if (cfg_final) begin final_cnt++; final_cyc = cyc; end
                    idx++;
                end
                inflight += int'(ram_en) - int'(cfg_valid && cfg_ready);
                if (ram_en || cfg_valid) chk("inflight_le2", 64'(inflight <= 2), 64'(1));
                hold = cfg_valid && !cfg_ready;
                held = {cfg_last, cfg_final, cfg_data};
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    if (exp_n > 0) chk("done_after_final", 64'(cyc), 64'(final_cyc + 1));
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_start(input logic [AW-1:0] b, input int len, input int lp);
        build(b, len, lp);
        step();
        base_addr = b;
        ctx_len   = (AW+1)'(len);
        loops     = LW'(lp);
        start     = 1'b1;
        start_cyc = cyc;
        step();
        start     = 1'b0;
        base_addr = AW'($urandom);
        ctx_len   = (AW+1)'($urandom);
        loops     = LW'($urandom);
    endtask

    task automatic finish_run(input string name, input int bound);
        int k = 0;
        while (done_cnt == 0 && k < bound) begin
            step();
            k++;
        end
        if (done_cnt == 0) chk({name, "_timeout"}, 64'(0), 64'(1));
        repeat (3) step();
        chk({name, "_words"}, 64'(idx), 64'(exp_n));
        chk({name, "_reads"}, 64'(aidx), 64'(exp_n));
        chk({name, "_done_cnt"}, 64'(done_cnt), 64'(1));
        chk({name, "_busy_idle"}, 64'(busy), 64'(0));
    endtask

    task automatic test_basic(input string name);
        cfg_ready = 1'b1;
        do_start(10'h010, 4, 1);
        finish_run(name, 100);
        chk({name, "_first_valid"}, 64'(first_valid_cyc), 64'(start_cyc + 3));
        chk({name, "_addr0"}, 64'(addr_log[0]), 64'(10'h010));
        chk({name, "_addr3"}, 64'(addr_log[3]), 64'(10'h013));
        chk({name, "_final_cyc"}, 64'(final_cyc), 64'(start_cyc + 6));
        chk({name, "_done_cyc"}, 64'(done_cyc), 64'(start_cyc + 7));
        chk({name, "_last_final"}, 64'({last_cnt[7:0], final_cnt[7:0]}), 64'(16'h0101));
    endtask

    initial begin
        fork
            compare_loop();
            forever begin
                @(posedge clk);
                #1;
                if (rnd_ready) cfg_ready = 1'($urandom_range(0, 1));
            end
        join_none

        repeat (2) step();
        chk("reset_outputs", 64'({busy, done, ram_en, ram_addr, cfg_valid, cfg_data, cfg_last, cfg_final}), 64'(0));
        rst_n = 1'b1;
        step();

        test_basic("t1");

        cfg_ready = 1'b1;
        do_start(10'h3FE, 4, 2);
        finish_run("t2", 100);
        chk("t2_addr1", 64'(addr_log[1]), 64'(10'h3FF));
        chk("t2_addr2", 64'(addr_log[2]), 64'(10'h000));
        chk("t2_addr4", 64'(addr_log[4]), 64'(10'h3FE));
        chk("t2_addr7", 64'(addr_log[7]), 64'(10'h001));
        chk("t2_last_cnt", 64'(last_cnt), 64'(2));
        chk("t2_final_cnt", 64'(final_cnt), 64'(1));
        chk("t2_done_cyc", 64'(done_cyc), 64'(start_cyc + 11));

        rnd_ready = 1;
        do_start(10'h123, 8, 1);
        finish_run("t3a", 500);
        do_start(10'h3FD, 5, 3);
        finish_run("t3b", 800);
        rnd_ready = 0;
        step();
        cfg_ready = 1'b1;

        do_start(10'h050, 0, 3);
        finish_run("t4a", 20);
        chk("t4a_done_cyc", 64'(done_cyc), 64'(start_cyc + 1));
        chk("t4a_no_reads", 64'(en_cnt), 64'(0));
        chk("t4a_no_valid", 64'(valid_cnt), 64'(0));
        do_start(10'h050, 5, 0);
        finish_run("t4b", 20);
        chk("t4b_done_cyc", 64'(done_cyc), 64'(start_cyc + 1));
        chk("t4b_no_reads", 64'(en_cnt), 64'(0));

        cfg_ready = 1'b0;
        do_start(10'h040, 8, 1);
        step();
        step();
        step();
        chk("t5_fifo_full_valid", 64'({cfg_valid, cfg_data}), 64'({1'b1, mem_word(10'h040)}));
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t5_after_abort", 64'({busy, cfg_valid, done}), 64'(0));
        gen++;
        repeat (6) step();
        chk("t5_no_done", 64'(done_cnt), 64'(0));
        chk("t5_no_reads", 64'(en_cnt), 64'(0));
        cfg_ready = 1'b1;
        base_addr = 10'h020;
        ctx_len   = 11'd4;
        loops     = 8'd1;
        start     = 1'b1;
        abort     = 1'b1;
        step();
        start     = 1'b0;
        abort     = 1'b0;
        chk("t5_abort_beats_start", 64'({busy, done}), 64'(0));
        test_basic("t5_restart");

        do_start(10'h010, 4, 1);
        step();
        step();
        gen++;
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_async_reset", 64'({busy, done, ram_en, ram_addr, cfg_valid, cfg_data, cfg_last, cfg_final}), 64'(0));
        repeat (2) step();
        rst_n = 1'b1;
        step();
        test_basic("t6_after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
